// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the instruction/data memory arbiter.
//   arb_state_t : arbiter FSM states
//   STARVE_W    : width of the fetch starvation counter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2
  } arb_state_t;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/ctrl_bus_if.sv
// ctrl_bus_if
// Shared control bus carrying the single clock and the asynchronous,
// active-high reset.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
interface ctrl_bus_if;
  logic clk;
  logic rst;

  modport central (
    input clk,
    input rst
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at MAX and can be cleared synchronously.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : count up by one (ignored once out == MAX)
//   clr      : return to zero; wins over inc
//   out      : current count
module sat_counter #(
  parameter int           N   = 4,
  parameter logic [N-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [N-1:0] out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
    end else if (clr) begin
      out <= '0;
    end else if (inc && (out != MAX)) begin
      out <= out + N'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port backing memory between the fetch stage and the
// memory stage. One access is in flight at a time; the granted request is
// latched and held on the memory port until m_ack. Data wins ties unless
// fetch has lost STARVE_MAX arbitrations in a row.
//
// Handshake: a requester holds x_req high; the access completes in the
// cycle where x_ready is high (x_ready = m_ack & x_req while x is served).
// The memory side sees m_req high from grant until (and including) the
// m_ack cycle; m_ack outside of service is ignored.
//
// Ports:
//   ctrl_bus          : clock and asynchronous active-high reset
//   i_req/i_addr      : fetch read request
//   i_rdata/i_ready   : fetch read data / completion
//   d_req/d_we/d_addr/d_wdata : memory-stage access request
//   d_rdata/d_ready   : memory-stage read data / completion
//   m_req/m_we/m_addr/m_wdata : backing memory request
//   m_rdata/m_ack     : backing memory read data / completion pulse
//   stall_F/stall_M   : hold requests for the hazard unit
//   conflict_cnt      : saturating count of cycles with both requesters waiting
//   arb_state         : current FSM state (debug)
//   starve_cnt        : consecutive fetch losses (debug)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  ctrl_bus_if.central         ctrl_bus,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ready,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ack,
  output logic                stall_F,
  output logic                stall_M,
  output logic [CNT_W-1:0]    conflict_cnt,
  output logic [1:0]          arb_state,
  output logic [STARVE_W-1:0] starve_cnt
);

  arb_state_t          state;
  arb_state_t          state_next;
  logic                grant_i;
  logic                grant_d;
  logic                starve_full;
  logic                conflict;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;

  assign starve_full = (starve_cnt == STARVE_W'(STARVE_MAX));

  // State register
  always_ff @(posedge ctrl_bus.clk or posedge ctrl_bus.rst) begin
    if (ctrl_bus.rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and grant decision. Grants are only made from ARB_IDLE,
  // which guarantees one low m_req cycle between accesses.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (d_req && !(i_req && starve_full)) begin
          grant_d    = 1'b1;
          state_next = ARB_SERVE_D;
        end else if (i_req) begin
          grant_i    = 1'b1;
          state_next = ARB_SERVE_I;
        end
      end
      ARB_SERVE_I, ARB_SERVE_D: begin
        if (m_ack) begin
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // Request latches: frozen from grant until the next grant, so the memory
  // port is immune to requester input changes during service. Write data is
  // left untouched on a fetch grant since fetch never writes.
  always_ff @(posedge ctrl_bus.clk or posedge ctrl_bus.rst) begin
    if (ctrl_bus.rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else if (grant_d) begin
      addr_q  <= d_addr;
      we_q    <= d_we;
      wdata_q <= d_wdata;
    end else if (grant_i) begin
      addr_q  <= i_addr;
      we_q    <= 1'b0;
    end
  end

  assign m_req   = (state != ARB_IDLE);
  assign m_we    = m_req & we_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;

  // A requester that dropped its req mid-service gets no ready pulse, but
  // the memory access itself still completes.
  assign i_ready = (state == ARB_SERVE_I) & m_ack & i_req;
  assign d_ready = (state == ARB_SERVE_D) & m_ack & d_req;
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  assign stall_F = i_req & ~i_ready;
  assign stall_M = d_req & ~d_ready;

  assign conflict  = i_req & d_req & ~i_ready & ~d_ready;
  assign arb_state = state;

  // Counts fetch losses: data granted while fetch was also asking.
  sat_counter #(
    .N   (STARVE_W),
    .MAX (STARVE_W'(STARVE_MAX))
  ) u_starve (
    .clk (ctrl_bus.clk),
    .rst (ctrl_bus.rst),
    .inc (grant_d & i_req),
    .clr (grant_i),
    .out (starve_cnt)
  );

  sat_counter #(
    .N   (CNT_W),
    .MAX ({CNT_W{1'b1}})
  ) u_conflict (
    .clk (ctrl_bus.clk),
    .rst (ctrl_bus.rst),
    .inc (conflict),
    .clr (1'b0),
    .out (conflict_cnt)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a transaction-level reference model plus an access scoreboard.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int STARVE_MAX = 4;
  localparam int CNT_MAX    = 65535;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ctrl_bus_if bus ();
  assign bus.clk = clk;
  assign bus.rst = rst;

  // ---------------- DUT ----------------
  logic        i_req, d_req, d_we, m_ack;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_ready, d_ready, m_req, m_we, stall_F, stall_M;
  logic [15:0] conflict_cnt;
  logic [1:0]  arb_state;
  logic [3:0]  starve_cnt;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX), .CNT_W(16)
  ) dut (
    .ctrl_bus     (bus),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .i_rdata      (i_rdata),
    .i_ready      (i_ready),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_ready      (d_ready),
    .m_req        (m_req),
    .m_we         (m_we),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_rdata      (m_rdata),
    .m_ack        (m_ack),
    .stall_F      (stall_F),
    .stall_M      (stall_M),
    .conflict_cnt (conflict_cnt),
    .arb_state    (arb_state),
    .starve_cnt   (starve_cnt)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One outstanding access described by who owns it and what it carries.
  bit          mdl_busy;
  bit          mdl_who_d;
  logic [31:0] mdl_addr_l;
  bit          mdl_we_l;
  logic [31:0] mdl_wd_l;
  int          mdl_starve;
  int          mdl_conf;
  bit          e_ir, e_dr;
  logic [64:0] exp_q[$];

  task automatic model_reset();
    mdl_busy   = 0;
    mdl_who_d  = 0;
    mdl_addr_l = '0;
    mdl_we_l   = 0;
    mdl_wd_l   = '0;
    mdl_starve = 0;
    mdl_conf   = 0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    logic [64:0] ent;
    logic [1:0]  exp_state;
    e_ir = mdl_busy && !mdl_who_d && m_ack && i_req;
    e_dr = mdl_busy &&  mdl_who_d && m_ack && d_req;
    exp_state = !mdl_busy ? ARB_IDLE : (mdl_who_d ? ARB_SERVE_D : ARB_SERVE_I);
    check_val("m_req",        m_req,        mdl_busy);
    check_val("m_we",         m_we,         mdl_busy && mdl_we_l);
    check_val("m_addr",       m_addr,       mdl_addr_l);
    check_val("m_wdata",      m_wdata,      mdl_wd_l);
    check_val("i_ready",      i_ready,      e_ir);
    check_val("d_ready",      d_ready,      e_dr);
    check_val("i_rdata",      i_rdata,      m_rdata);
    check_val("d_rdata",      d_rdata,      m_rdata);
    check_val("stall_F",      stall_F,      i_req && !e_ir);
    check_val("stall_M",      stall_M,      d_req && !e_dr);
    check_val("conflict_cnt", conflict_cnt, mdl_conf);
    check_val("starve_cnt",   starve_cnt,   mdl_starve);
    check_val("arb_state",    arb_state,    exp_state);
    check_val("ready_excl",   i_ready && d_ready, 1'b0);
    if (mdl_busy && m_ack) begin
      if (exp_q.size() == 0) begin
        check_val("sb_empty", 1'b1, 1'b0);
      end else begin
        ent = exp_q.pop_front();
        check_val("sb_access", {m_we, m_addr, m_wdata}, ent);
      end
    end
  endtask

  task automatic model_advance();
    if (rst) return;
    if (i_req && d_req && !e_ir && !e_dr && mdl_conf < CNT_MAX) mdl_conf++;
    if (mdl_busy) begin
      if (m_ack) mdl_busy = 0;
    end else if (d_req && !(i_req && mdl_starve == STARVE_MAX)) begin
      mdl_busy   = 1;
      mdl_who_d  = 1;
      mdl_addr_l = d_addr;
      mdl_we_l   = d_we;
      mdl_wd_l   = d_wdata;
      if (i_req && mdl_starve < STARVE_MAX) mdl_starve++;
      exp_q.push_back({mdl_we_l, mdl_addr_l, mdl_wd_l});
    end else if (i_req) begin
      mdl_busy   = 1;
      mdl_who_d  = 0;
      mdl_addr_l = i_addr;
      mdl_we_l   = 0;
      mdl_starve = 0;
      exp_q.push_back({mdl_we_l, mdl_addr_l, mdl_wd_l});
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are set after posedge+#1; outputs are checked at the negedge.
  task automatic sample();
    @(negedge clk);
    if (rst) model_reset();
    check_outputs();
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    sample();
    tick();
  endtask

  task automatic idle_inputs();
    i_req = 0; d_req = 0; d_we = 0; m_ack = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    i_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
    model_reset();

    // Reset held
    repeat (2) begin
      sample();
      check_val("rst_m_req", m_req, 1'b0);
      check_val("rst_conflict", conflict_cnt, 16'd0);
      tick();
    end
    rst = 0;

    // Reset release then first fetch
    i_req = 1; i_addr = 32'h40;
    sample();
    check_val("t1_m_req_low", m_req, 1'b0);
    tick();
    m_ack = 1; m_rdata = 32'h2402000A;
    sample();
    check_val("t1_m_req_high", m_req, 1'b1);
    check_val("t1_i_ready", i_ready, 1'b1);
    check_val("t1_i_rdata", i_rdata, 32'h2402000A);
    tick();
    idle_inputs();
    cycle();

    // Tie goes to data
    i_req = 1; i_addr = 32'h80;
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    cycle();
    sample();
    check_val("t2_m_we", m_we, 1'b1);
    check_val("t2_m_addr", m_addr, 32'h100);
    check_val("t2_stall_F", stall_F, 1'b1);
    tick();
    m_ack = 1;
    sample();
    check_val("t2_d_ready", d_ready, 1'b1);
    tick();
    d_req = 0; d_we = 0; m_ack = 0;
    cycle();           // fetch granted
    m_ack = 1;
    sample();
    check_val("t2_i_ready", i_ready, 1'b1);
    tick();
    idle_inputs();
    cycle();

    // Starvation guard: data wins four ties, fetch wins the fifth
    i_req = 1; d_req = 1; d_we = 0;
    for (int k = 0; k < 9; k++) begin
      d_addr = $urandom; m_ack = m_req;
      cycle();
    end
    m_ack = m_req;
    sample();
    check_val("t3_fetch_granted", arb_state, ARB_SERVE_I);
    check_val("t3_starve_zero", starve_cnt, 4'd0);
    tick();
    idle_inputs();
    cycle();

    // Latched address is stable while m_ack is late
    d_req = 1; d_we = 0; d_addr = 32'h100;
    cycle();
    d_addr = 32'h200;
    for (int k = 0; k < 5; k++) begin
      sample();
      check_val("t4_m_addr_hold", m_addr, 32'h100);
      tick();
    end
    m_ack = 1;
    sample();
    check_val("t4_d_ready", d_ready, 1'b1);
    tick();
    idle_inputs();
    cycle();

    // Fetch abort, then stray m_ack in idle
    i_req = 1; i_addr = $urandom;
    cycle();
    i_req = 0; m_ack = 1;
    sample();
    check_val("t5_abort_no_ready", i_ready, 1'b0);
    tick();
    sample();
    check_val("t5_back_idle", arb_state, ARB_IDLE);
    check_val("t5_stray_no_ready", i_ready | d_ready, 1'b0);
    tick();
    sample();
    check_val("t5_still_idle", arb_state, ARB_IDLE);
    tick();
    idle_inputs();

    // Reset in the middle of a data access
    d_req = 1; d_we = 1; d_addr = 32'h300; d_wdata = $urandom;
    cycle();
    rst = 1;
    #1;
    check_val("t6_m_req_drop", m_req, 1'b0);
    cycle();
    rst = 0; m_ack = 1;
    sample();
    check_val("t6_late_ack", d_ready, 1'b0);
    tick();
    idle_inputs();
    cycle();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      i_req   = ($urandom_range(0, 3) != 0);
      d_req   = ($urandom_range(0, 2) != 0);
      d_we    = $urandom_range(0, 1);
      i_addr  = $urandom;
      d_addr  = $urandom;
      d_wdata = $urandom;
      m_rdata = $urandom;
      m_ack   = $urandom_range(0, 1);
      if (rst) rst = 0;
      else if ($urandom_range(0, 199) == 0) rst = 1;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares one single-port backing memory between the fetch stage (instruction port) and the memory stage (data port) of the 5-stage pipeline.
- Grants one access at a time and holds the granted request stable until the memory acknowledges it.
- Data wins ties; a bounded starvation guard guarantees fetch progress.
- Emits stall requests for the hazard unit and a saturating conflict counter for performance monitoring.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive fetch losses after which fetch wins the next tie (1..15)
- CNT_W, 16, conflict counter width

Ports:
- ctrl_bus  input  ctrl_bus_if.central  shared control bus. Carries the one clock and the asynchronous, active-high reset. All state is reset asynchronously and clocked on the rising edge.
- i_req  input  1  fetch requests a read
- i_addr  input  ADDR_W  fetch address
- i_rdata  output  DATA_W  fetch read data (equals m_rdata)
- i_ready  output  1  fetch access completes this cycle
- d_req  input  1  memory stage requests an access
- d_we  input  1  1 = write, 0 = read
- d_addr  input  ADDR_W  data address
- d_wdata  input  DATA_W  write data
- d_rdata  output  DATA_W  data read data (equals m_rdata)
- d_ready  output  1  data access completes this cycle
- m_req  output  1  access to backing memory
- m_we  output  1  write enable
- m_addr  output  ADDR_W  memory address
- m_wdata  output  DATA_W  memory write data
- m_rdata  input  DATA_W  memory read data, valid with m_ack
- m_ack  input  1  one-cycle completion pulse
- stall_F  output  1  fetch must hold
- stall_M  output  1  memory stage must hold
- conflict_cnt  output  CNT_W  saturating count of cycles in which both requesters wait

## Operation
States: ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D.

- **ARB_IDLE**
  - d_req only: go to ARB_SERVE_D. Latch d_addr, d_wdata and d_we.
  - i_req only: go to ARB_SERVE_I. Latch i_addr; latched we = 0.
  - Both: fetch wins only if starve_cnt == STARVE_MAX; otherwise data wins.
- **ARB_SERVE_x**
  - m_req = 1; m_addr, m_we and m_wdata come from the latched registers.
  - On m_ack: x_ready = m_ack & x_req; return to ARB_IDLE.
- **starve_cnt** (width 4):
  - +1, saturating at STARVE_MAX, when data is granted while i_req = 1.
  - Cleared to 0 when fetch is granted.
- **conflict_cnt**: +1 on every cycle with i_req & d_req & ~i_ready & ~d_ready; saturates at all-ones.
- stall_F = i_req & ~i_ready; stall_M = d_req & ~d_ready. Both are combinational.
- **Requester drops req mid-service**: the access still completes at memory (writes take effect). The matching ready stays 0.
- **m_ack in ARB_IDLE**: ignored; no ready pulse, no state change.
- **Reset mid-access**: state returns to ARB_IDLE and m_req drops immediately. Any late m_ack is ignored.

## Timing
- **Reset values**: state ARB_IDLE; m_req, m_we, i_ready, d_ready = 0; m_addr and m_wdata = 0; starve_cnt and conflict_cnt = 0. stall_F and stall_M follow their inputs (0 when no requests).
- **Grant latency**: req seen in ARB_IDLE at cycle t, m_req high from t+1.
- **Minimum access**: 2 cycles (req at t, m_ack at t+1, ready at t+1).
- **Back-to-back**: after completion at t, the next grant is decided at t+1 and m_req is high again at t+2. m_req has at least one low cycle between accesses.
- **Latched signals**: m_addr, m_we and m_wdata stay constant from grant until m_ack, whatever the requester inputs do.
- **Ready**: i_ready and d_ready are never high in the same cycle; each is high for at most one cycle per access.

## Structure
- Package mem_arb_pkg holds:
  - enum arb_state_t {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D}
  - localparam STARVE_W = 4
- Sub-module sat_counter (parameters N and MAX; ports inc, clr, out) is instantiated twice: once for starve_cnt and once for conflict_cnt.
- FSM, latches and output muxing live in mem_arbiter.

## Test plan
1. **Reset**: hold reset, then release.
   - While reset is held: m_req = 0, conflict_cnt = 0.
   - After release, i_req = 1, i_addr = 0x40, m_ack one cycle later: m_req rises 1 cycle after i_req; i_ready pulses with m_ack; i_rdata = m_rdata = 0x2402000A.
2. **Tie to data**: both requests from idle; d_we = 1, d_addr = 0x100, d_wdata = 0xDEADBEEF.
   - Write is served first: m_we = 1, m_addr = 0x100.
   - stall_F stays high until the fetch completes.
   - conflict_cnt increments on every cycle both requesters wait.
3. **Starvation guard**: hold i_req and re-raise d_req for 4 consecutive data accesses.
   - 5th arbitration with both requesting grants fetch.
   - starve_cnt reads 0 after that grant.
4. **Stability**: change d_addr from 0x100 to 0x200 while m_ack is delayed 5 cycles → m_addr stays 0x100 throughout.
5. **Abort**: drop i_req before m_ack → i_ready stays 0, FSM returns to ARB_IDLE.
   - Stray m_ack in ARB_IDLE → no ready pulse, no state change.
6. **Reset mid-access**: assert reset during ARB_SERVE_D → m_req falls immediately; a later m_ack produces no d_ready.
